// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle 32-bit DIV/DIVU sequencer producing {remainder, quotient}.
// Four-state FSM (IDLE, DIVZERO, ON, END) drives a radix-2 restoring divider.
// Optional macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [64:0] rq;          // {partial remainder, dividend/quotient bits}
  logic [31:0] divisor;
  logic        sign1, sign2, is_signed;

  logic [31:0] mag1, mag2;
  logic        accept, early, last_step;
  logic [64:0] shifted, step_rq;
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] q_raw, r_raw, q_fix, r_fix;
  logic        unused_bits;

  assign mag1      = (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
  assign mag2      = (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;
  assign accept    = (state == S_IDLE) && div_start_i && !annul_i;
  assign last_step = (cnt == 6'd31);

`ifdef DIV_EARLY_OUT_EN
  assign early = (opdata2_i != 32'd0) && (mag1 < mag2);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift left, subtract divisor from the upper half if it fits.
  assign shifted  = {rq[63:0], 1'b0};
  assign trial_ge = shifted[64:32] >= {1'b0, divisor};
  assign trial    = shifted[64:32] - {1'b0, divisor};
  assign step_rq  = trial_ge ? {trial, shifted[31:1], 1'b1} : shifted;

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  assign q_raw = step_rq[31:0];
  assign r_raw = step_rq[63:32];
  assign q_fix = (is_signed && (sign1 ^ sign2)) ? 32'd0 - q_raw : q_raw;
  assign r_fix = (is_signed && sign1) ? 32'd0 - r_raw : r_raw;

  // Top bit never survives a step (remainder < divisor < 2^32).
  assign unused_bits = rq[64] ^ step_rq[64];

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state, ready and stall; annul overrides every transition.
  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    stall_o   = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        stall_o = 1'b1;
        if (opdata2_i == 32'd0) state_nxt = S_DIVZERO;
        else if (early)         state_nxt = S_END;
        else                    state_nxt = S_ON;
      end
      S_DIVZERO: begin
        stall_o   = 1'b1;
        state_nxt = S_END;
      end
      S_ON: begin
        stall_o = 1'b1;
        if (last_step) state_nxt = S_END;
      end
      S_END: begin
        ready_o   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (annul_i) begin
      state_nxt = S_IDLE;
      ready_o   = 1'b0;
    end
  end

  // Operand capture, iteration and result registration on entry to END.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= 6'd0;
      rq        <= 65'd0;
      divisor   <= 32'd0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      is_signed <= 1'b0;
      result_o  <= 64'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt       <= 6'd0;
          rq        <= {33'd0, mag1};
          divisor   <= mag2;
          sign1     <= opdata1_i[31];
          sign2     <= opdata2_i[31];
          is_signed <= signed_div_i;
          if (early && opdata2_i != 32'd0) result_o <= {opdata1_i, 32'd0};
        end
        S_DIVZERO: if (!annul_i) result_o <= 64'd0;
        S_ON: if (!annul_i) begin
          rq <= step_rq;
          if (last_step) begin
            cnt      <= 6'd0;
            result_o <= {r_fix, q_fix};
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed + randomized checks of div_sequencer against an arithmetic model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_start_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] last_res = 64'd0;

  div_sequencer dut (
    .clk(clk), .resetn(resetn), .div_start_i(div_start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from plain 64-bit arithmetic (truncating division).
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Expected accept-to-ready latency in cycles.
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? 32'd0 - a : a;
    mb = (s && b[31]) ? 32'd0 - b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    if (ma == mb) return 33;
    return 33;
  endfunction

  // Issue one divide; cont = launch from an END cycle with start still high; keep = leave start high.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit cont, input bit keep);
    logic [63:0] exp;
    int lat, cyc;
    bit got;
    exp = model(a, b, s);
    lat = exp_lat(a, b, s);
    if (cont) begin
      opdata1_i = a; opdata2_i = b; signed_div_i = s; div_start_i = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      opdata1_i = a; opdata2_i = b; signed_div_i = s; div_start_i = 1'b1;
      #1;
    end
    nvec++;
    if (stall_o !== 1'b1) begin
      nerr++; $display("FAIL stall_accept a=%h b=%h got=%b want=1", a, b, stall_o);
    end
    cyc = 0; got = 0;
    while (!got && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (ready_o === 1'b1) got = 1;
      else begin
        nvec++;
        if (stall_o !== 1'b1) begin
          nerr++; $display("FAIL stall_busy cyc=%0d got=%b want=1", cyc, stall_o);
        end
        // Busy-time input changes must not disturb the operation.
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
      end
    end
    nvec++;
    if (!got || cyc != lat) begin
      nerr++; $display("FAIL latency a=%h b=%h s=%b got=%0d want=%0d", a, b, s, got ? cyc : -1, lat);
    end
    nvec++;
    if (result_o !== exp) begin
      nerr++; $display("FAIL result a=%h b=%h s=%b got=%h want=%h", a, b, s, result_o, exp);
    end
    nvec++;
    if (stall_o !== 1'b0) begin
      nerr++; $display("FAIL stall_end got=%b want=0", stall_o);
    end
    last_res = exp;
    if (!keep) begin
      div_start_i = 1'b0;
      @(posedge clk); #1;
      nvec++;
      if (ready_o !== 1'b0 || stall_o !== 1'b0 || result_o !== exp) begin
        nerr++; $display("FAIL hold rdy=%b stall=%b res=%h want 0/0/%h", ready_o, stall_o, result_o, exp);
      end
    end
  endtask

  task automatic no_ready_for(input int n, input string tag);
    bit seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) seen = 1;
    end
    nvec++;
    if (seen) begin
      nerr++; $display("FAIL %s_no_ready got ready=1 want 0", tag);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (ready_o !== 1'b0) begin nerr++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    nvec++; if (result_o !== 64'd0) begin nerr++; $display("FAIL reset_result got=%h want=0", result_o); end
    @(negedge clk);
    resetn = 1'b1;
    last_res = 64'd0;
  endtask

  task automatic test_directed;
    run_div(32'd100, 32'd7, 1'b0, 0, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0);
    run_div(32'd12345, 32'd0, 1'b1, 0, 0);
    run_div(32'd3, 32'd10, 1'b0, 0, 0);
    run_div(32'hFFFFFFFD, 32'd10, 1'b1, 0, 0);
    run_div(32'h80000000, 32'd1, 1'b0, 0, 0);
    run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0);
  endtask

  task automatic test_annul;
    int cyc;
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; div_start_i = 1'b1;
    cyc = 0;
    while (cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    annul_i = 1'b1; div_start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    nvec++; if (ready_o !== 1'b0) begin nerr++; $display("FAIL annul_ready got=%b want=0", ready_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL annul_stall got=%b want=0", stall_o); end
    nvec++; if (result_o !== last_res) begin nerr++; $display("FAIL annul_result got=%h want=%h", result_o, last_res); end
    no_ready_for(40, "annul");
  endtask

  task automatic test_back_to_back;
    run_div(32'd100, 32'd7, 1'b0, 0, 1);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1, 1);
    run_div(32'd50, 32'd0, 1'b0, 1, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic s;
    int mode;
    repeat (24) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      mode = $urandom_range(0, 5);
      case (mode)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = $urandom_range(0, 200);
        3: a = 32'h80000000;
        default: ;
      endcase
      run_div(a, b, s, 0, 0);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; div_start_i = 1'b1;
    cyc = 0;
    while (cyc < 15) begin
      @(posedge clk); #1; cyc++;
    end
    resetn = 1'b0; annul_i = 1'b1; div_start_i = 1'b0;
    @(posedge clk); #1;
    nvec++; if (ready_o !== 1'b0) begin nerr++; $display("FAIL rstmid_ready got=%b want=0", ready_o); end
    nvec++; if (stall_o !== 1'b0) begin nerr++; $display("FAIL rstmid_stall got=%b want=0", stall_o); end
    nvec++; if (result_o !== 64'd0) begin nerr++; $display("FAIL rstmid_result got=%h want=0", result_o); end
    @(negedge clk);
    resetn = 1'b1; annul_i = 1'b0;
    last_res = 64'd0;
    no_ready_for(40, "rstmid");
    run_div(32'd1000, 32'd33, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_annul;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
